// File: rtl/load_unit_pkg.sv
// rtl/load_unit_pkg.sv - shared load-type encodings, load FSM states and alignment helper
//
// Purpose : constants and types shared by load_unit and load_extract.
// Contents: LSEL_* load-type encodings, load_state_e FSM state enum,
//           is_misaligned() alignment check on load type and address offset.
package load_unit_pkg;

    localparam logic [2:0] LSEL_LW  = 3'b000;
    localparam logic [2:0] LSEL_LH  = 3'b001;
    localparam logic [2:0] LSEL_LHU = 3'b010;
    localparam logic [2:0] LSEL_LB  = 3'b011;
    localparam logic [2:0] LSEL_LBU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } load_state_e;

    // Unused encodings 101-111 behave as lw, so they need word alignment too.
    function automatic logic is_misaligned(input logic [2:0] lsel, input logic [1:0] offset);
        logic mis;
        case (lsel)
            LSEL_LH, LSEL_LHU: mis = offset[0];
            LSEL_LB, LSEL_LBU: mis = 1'b0;
            default:           mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - combinational lane select and sign/zero extension of a loaded word
//
// Purpose: picks the addressed byte/halfword out of a little-endian word and extends it.
// Ports  : word   in  32  read data word
//          offset in   2  byte offset within the word
//          lsel   in   3  load type (LSEL_* encodings)
//          result out 32  extended load result
module load_extract
    import load_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  lsel,
    output logic [31:0] result
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
    end

    always_comb begin
        case (lsel)
            LSEL_LH:  result = {{16{half_sel[15]}}, half_sel};
            LSEL_LHU: result = {16'h0000, half_sel};
            LSEL_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            LSEL_LBU: result = {24'h000000, byte_sel};
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - multi-cycle MEM-stage load unit with request/grant memory handshake
//
// Purpose: accepts one load, issues a word-aligned read, extends the returned data and
//          hands one writeback beat to WB while stalling the pipeline.
// Ports  : Clk, Rst_n                      clock, async active-low reset
//          LdValid, LdAddr, Lsel, LdDest   load request from MEM
//          Stall, AddrErr                  pipeline freeze, misaligned-load flag
//          MemReq, MemAddr, MemGnt         read request handshake
//          MemRValid, MemRData             read response
//          WbValid, WbData, WbDest         writeback beat
module load_unit
    import load_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        LdValid,
    input  logic [31:0] LdAddr,
    input  logic [2:0]  Lsel,
    input  logic [4:0]  LdDest,
    output logic        Stall,
    output logic        AddrErr,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemGnt,
    input  logic        MemRValid,
    input  logic [31:0] MemRData,
    output logic        WbValid,
    output logic [31:0] WbData,
    output logic [4:0]  WbDest
);

    load_state_e state, state_n;

    logic [29:0] word_addr_q;
    logic [2:0]  lsel_q;
    logic [1:0]  off_q;
    logic [4:0]  dest_q;

    // Writeback-side copies are loaded only when the response lands, so WbData/WbDest
    // hold steady while the next load is captured and in flight.
    logic [31:0] rdata_q;
    logic [2:0]  wb_lsel_q;
    logic [1:0]  wb_off_q;
    logic [4:0]  wb_dest_q;

    logic mis;
    logic accept;
    logic resp;

    assign mis    = is_misaligned(Lsel, LdAddr[1:0]);
    assign accept = (state == ST_IDLE) && LdValid && !mis;
    assign resp   = (state == ST_WAIT) && MemRValid;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_REQ;
            ST_REQ:  if (MemGnt) state_n = ST_WAIT;
            ST_WAIT: if (MemRValid) state_n = ST_DONE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            word_addr_q <= '0;
            lsel_q      <= '0;
            off_q       <= '0;
            dest_q      <= '0;
        end else if (accept) begin
            word_addr_q <= LdAddr[31:2];
            lsel_q      <= Lsel;
            off_q       <= LdAddr[1:0];
            dest_q      <= LdDest;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdata_q   <= '0;
            wb_lsel_q <= '0;
            wb_off_q  <= '0;
            wb_dest_q <= '0;
        end else if (resp) begin
            rdata_q   <= MemRData;
            wb_lsel_q <= lsel_q;
            wb_off_q  <= off_q;
            wb_dest_q <= dest_q;
        end
    end

    load_extract u_extract (
        .word   (rdata_q),
        .offset (wb_off_q),
        .lsel   (wb_lsel_q),
        .result (WbData)
    );

    // Combinational outputs are qualified by Rst_n so they fall the instant reset asserts,
    // even if MEM keeps LdValid high.
    assign Stall   = Rst_n && (accept || (state == ST_REQ) || (state == ST_WAIT));
    assign AddrErr = Rst_n && (state == ST_IDLE) && LdValid && mis;
    assign MemReq  = (state == ST_REQ);
    assign MemAddr = {word_addr_q, 2'b00};
    assign WbValid = (state == ST_DONE);
    assign WbDest  = wb_dest_q;

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - scoreboard testbench for load_unit
module tb_load_unit;
    import load_unit_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        LdValid;
    logic [31:0] LdAddr;
    logic [2:0]  Lsel;
    logic [4:0]  LdDest;
    logic        Stall;
    logic        AddrErr;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemGnt;
    logic        MemRValid;
    logic [31:0] MemRData;
    logic        WbValid;
    logic [31:0] WbData;
    logic [4:0]  WbDest;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int errors = 0;
    int checks = 0;

    load_unit dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .LdValid   (LdValid),
        .LdAddr    (LdAddr),
        .Lsel      (Lsel),
        .LdDest    (LdDest),
        .Stall     (Stall),
        .AddrErr   (AddrErr),
        .MemReq    (MemReq),
        .MemAddr   (MemAddr),
        .MemGnt    (MemGnt),
        .MemRValid (MemRValid),
        .MemRData  (MemRData),
        .WbValid   (WbValid),
        .WbData    (WbData),
        .WbDest    (WbDest)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every writeback beat must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (WbValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got beat data 0x%08h dest %0d expected none at %0t",
                         WbData, WbDest, $time);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                chk("wb_data", WbData, e.data);
                chk("wb_dest", {27'd0, WbDest}, {27'd0, e.dest});
            end
        end
    end

    task automatic do_load(input logic [2:0] ls, input logic [31:0] addr, input logic [4:0] dest,
                           input logic [31:0] data, input logic [31:0] exp,
                           input int gw, input int rw, input bit spur);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        @(negedge Clk);
        LdValid = 1'b1; LdAddr = addr; Lsel = ls; LdDest = dest;
        #1;
        chk("stall_accept", {31'd0, Stall}, 32'd1);
        chk("adderr_aligned", {31'd0, AddrErr}, 32'd0);
        exp_q.push_back('{exp, dest});
        @(negedge Clk);
        LdValid = 1'b0; LdAddr = 32'hFFFF_FFFF; Lsel = LSEL_LB; LdDest = 5'd31;
        for (int i = 0; i < gw; i++) begin
            MemGnt = 1'b0; MemRValid = spur; MemRData = 32'hBAD0_BAD0;
            #1;
            chk("req_held", {31'd0, MemReq}, 32'd1);
            chk("addr_held", MemAddr, waddr);
            chk("stall_req", {31'd0, Stall}, 32'd1);
            @(negedge Clk);
        end
        MemGnt = 1'b1; MemRValid = 1'b0;
        #1;
        chk("req_gnt", {31'd0, MemReq}, 32'd1);
        chk("mem_addr", MemAddr, waddr);
        chk("stall_gnt", {31'd0, Stall}, 32'd1);
        @(negedge Clk);
        MemGnt = 1'b0;
        for (int i = 0; i < rw; i++) begin
            MemRValid = 1'b0;
            #1;
            chk("stall_wait", {31'd0, Stall}, 32'd1);
            chk("req_off_wait", {31'd0, MemReq}, 32'd0);
            @(negedge Clk);
        end
        MemRValid = 1'b1; MemRData = data;
        #1;
        chk("stall_resp", {31'd0, Stall}, 32'd1);
        @(negedge Clk);
        MemRValid = 1'b0; MemRData = 32'h0;
        #1;
        chk("stall_done", {31'd0, Stall}, 32'd0);
        chk("wbvalid_done", {31'd0, WbValid}, 32'd1);
        @(negedge Clk);
        #1;
        chk("wbvalid_once", {31'd0, WbValid}, 32'd0);
        chk("wbdata_hold", WbData, exp);
    endtask

    task automatic do_misaligned(input logic [2:0] ls, input logic [31:0] addr);
        @(negedge Clk);
        LdValid = 1'b1; LdAddr = addr; Lsel = ls; LdDest = 5'd7;
        #1;
        chk("adderr", {31'd0, AddrErr}, 32'd1);
        chk("stall_mis", {31'd0, Stall}, 32'd0);
        chk("req_mis", {31'd0, MemReq}, 32'd0);
        @(negedge Clk);
        #1;
        chk("adderr_idle", {31'd0, AddrErr}, 32'd1);
        chk("req_mis_next", {31'd0, MemReq}, 32'd0);
        LdValid = 1'b0;
        #1;
        chk("adderr_clear", {31'd0, AddrErr}, 32'd0);
    endtask

    initial begin
        Rst_n = 1'b0; LdValid = 1'b0; LdAddr = 32'h0; Lsel = LSEL_LW; LdDest = 5'd0;
        MemGnt = 1'b0; MemRValid = 1'b0; MemRData = 32'h0;
        #12;
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_req", {31'd0, MemReq}, 32'd0);
        chk("rst_wbvalid", {31'd0, WbValid}, 32'd0);
        chk("rst_wbdata", WbData, 32'h0);
        chk("rst_memaddr", MemAddr, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        do_load(LSEL_LW,  32'h0000_0100, 5'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1'b0);
        do_load(LSEL_LB,  32'h0000_0103, 5'd4,  32'h80FF_1234, 32'hFFFF_FF80, 0, 0, 1'b0);
        do_load(LSEL_LBU, 32'h0000_0103, 5'd5,  32'h80FF_1234, 32'h0000_0080, 0, 0, 1'b0);
        do_load(LSEL_LB,  32'h0000_0101, 5'd6,  32'h80FF_1234, 32'h0000_0012, 0, 0, 1'b0);
        do_load(LSEL_LB,  32'h0000_0102, 5'd8,  32'h80FF_1234, 32'hFFFF_FFFF, 0, 0, 1'b0);
        do_load(LSEL_LBU, 32'h0000_0102, 5'd9,  32'h80FF_1234, 32'h0000_00FF, 0, 0, 1'b0);
        do_load(LSEL_LH,  32'h0000_0102, 5'd10, 32'h8001_7FFF, 32'hFFFF_8001, 0, 0, 1'b0);
        do_load(LSEL_LHU, 32'h0000_0100, 5'd11, 32'h8001_7FFF, 32'h0000_7FFF, 0, 0, 1'b0);
        do_load(LSEL_LH,  32'h0000_0100, 5'd12, 32'h8001_7FFF, 32'h0000_7FFF, 0, 0, 1'b0);
        do_load(3'b111,   32'h0000_0204, 5'd13, 32'h1357_9BDF, 32'h1357_9BDF, 0, 0, 1'b0);

        do_misaligned(LSEL_LW, 32'h0000_0102);
        do_misaligned(LSEL_LH, 32'h0000_0101);

        do_load(LSEL_LHU, 32'h0000_0302, 5'd14, 32'hA5A5_C3C3, 32'h0000_A5A5, 3, 4, 1'b1);

        // Reset while WAIT; a late response must be dropped.
        @(negedge Clk);
        LdValid = 1'b1; LdAddr = 32'h0000_0200; Lsel = LSEL_LW; LdDest = 5'd9;
        @(negedge Clk);
        LdValid = 1'b0; MemGnt = 1'b1;
        @(negedge Clk);
        MemGnt = 1'b0;
        #1;
        chk("stall_pre_rst", {31'd0, Stall}, 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", {31'd0, Stall}, 32'd0);
        chk("rst_mid_req", {31'd0, MemReq}, 32'd0);
        chk("rst_mid_wbvalid", {31'd0, WbValid}, 32'd0);
        chk("rst_mid_adderr", {31'd0, AddrErr}, 32'd0);
        chk("rst_mid_wbdata", WbData, 32'h0);
        chk("rst_mid_wbdest", {27'd0, WbDest}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        MemRValid = 1'b1; MemRData = 32'h1234_5678;
        @(negedge Clk);
        MemRValid = 1'b0;
        #1;
        chk("post_rst_stall", {31'd0, Stall}, 32'd0);
        chk("post_rst_wbvalid", {31'd0, WbValid}, 32'd0);
        repeat (2) @(negedge Clk);

        do_load(LSEL_LB, 32'h0000_0401, 5'd17, 32'h0000_F000, 32'hFFFF_FFF0, 1, 1, 1'b0);

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_unit.md
# load_unit

Multi-cycle load unit for the MEM stage of the MIPS pipeline, mirroring the store-side data formatter. It accepts one load per transaction and issues a word-aligned read to data memory over a request/grant and response handshake. It extracts the addressed byte or halfword from the returned word and sign- or zero-extends it. It stalls the pipeline while the load is outstanding and hands a single writeback beat to WB.

## Interface
Parameters: none; widths fixed at 32-bit data and address, 5-bit register index.
- Clk  in  1  pipeline clock; all state updates on rising edge
- Rst_n  in  1  asynchronous active-low reset
- LdValid  in  1  MEM stage holds a load instruction
- LdAddr  in  32  effective byte address
- Lsel  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101–111 treated as lw
- LdDest  in  5  destination register index
- Stall  out  1  freeze IF..MEM stages
- AddrErr  out  1  misaligned-load indication
- MemReq  out  1  read request to data memory
- MemAddr  out  32  word address, bits [1:0] forced to 0
- MemGnt  in  1  memory accepted request this cycle
- MemRValid  in  1  read data valid
- MemRData  in  32  read data word
- WbValid  out  1  writeback beat valid
- WbData  out  32  extended load result
- WbDest  out  5  destination register index

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset forces IDLE with all registered outputs at 0.
- Misaligned load: lw with LdAddr[1:0]≠0, or lh/lhu with LdAddr[0]=1.
- IDLE, LdValid, aligned:
  - capture Lsel, LdAddr[1:0], LdDest and {LdAddr[31:2],2'b00}.
  - go to REQ.
- IDLE, LdValid, misaligned:
  - AddrErr=1 combinationally.
  - No capture, no request, no stall, no writeback; remain IDLE.
- REQ:
  - MemReq=1 with MemAddr stable.
  - MemGnt=1 → WAIT.
  - MemGnt=0 → hold request unchanged.
- WAIT:
  - MemRValid=1 → register MemRData, go to DONE.
  - MemRValid is ignored in all other states.
- DONE:
  - WbValid=1 for exactly one cycle with WbData and WbDest.
  - Unconditionally go to IDLE; no new load is accepted in DONE.
- Stall = (IDLE & LdValid & aligned) | REQ | WAIT. Stall is low in DONE, so the load leaves MEM that cycle; it is never recaptured.
- Extraction uses little-endian lanes; byte k = word[8k+7:8k], and offset is the captured address[1:0].
  - lw: whole word.
  - lh/lhu: offset[1] selects [15:0] or [31:16]; lh sign-extends bit 15, lhu zero-extends.
  - lb/lbu: lane selected by offset; lb sign-extends bit 7, lbu zero-extends.
- WbData and WbDest hold their last value when WbValid=0; they are cleared only by reset.

## Timing
- Load presented at cycle t, with MemGnt at t+1 and MemRValid at t+2 (the earliest):
  - Stall high for t..t+2.
  - WbValid at t+3.
- Each extra grant or response wait cycle adds one stall cycle.
- MemRValid is never expected in the same cycle as MemGnt. If it arrives then, it is ignored.
- Stall and AddrErr are combinational from LdValid, LdAddr and Lsel in IDLE. All other outputs are registered.
- Reset mid-operation:
  - asynchronous return to IDLE; MemReq, Stall, WbValid and AddrErr drop immediately.
  - a later MemRValid for the abandoned request is ignored.

## Structure
- Shared pipeline package holds:
  - Lsel encoding constants (LSEL_LW, LSEL_LH, LSEL_LHU, LSEL_LB, LSEL_LBU).
  - the load FSM state enum.
- Sub-module load_extract: purely combinational lane select and extension. Inputs are word, offset and Lsel; output is the 32-bit result, computed from the registered read word.

## Test plan
- lw 0x100, MemGnt at t+1, MemRData 0xDEADBEEF at t+2 → Stall t..t+2, WbValid at t+3, WbData 0xDEADBEEF, WbDest echoed, MemAddr 0x100.
- lb 0x103 with data 0x80FF1234 → WbData 0xFFFFFF80, MemAddr 0x100. lbu at the same address → 0x00000080. lb 0x101 → 0x00000012.
- lh 0x102 with data 0x80017FFF → 0xFFFF8001. lhu 0x100 → 0x00007FFF. lh 0x100 → 0x00007FFF.
- lw 0x102 and lh 0x101 → AddrErr=1 while LdValid, MemReq=0, Stall=0, no WbValid.
- MemGnt held low 3 cycles and MemRValid delayed 4 cycles, with a spurious MemRValid during REQ → MemReq/MemAddr stable, Stall continuous, spurious beat ignored, exactly one WbValid.
- Rst_n low during WAIT, then MemRValid after release → all outputs 0 at once, state IDLE, no WbValid. The next load completes normally.
